// File: rtl/clock_ctrl.sv
// clock_ctrl: gated clock controller for the SAP-3 core and its peripherals.
// Produces N_CH gated copies of clk_in. The channels can free-run, single-step,
// run a fixed-length burst, or run divided. A CPU halt is sticky until an
// explicit resume.
//
// Ports:
//   clk_in     source clock
//   rst        asynchronous active-high reset
//   hlt        CPU halt request (level)
//   resume     one-cycle pulse, leaves HALT
//   mode       00 free-run, 01 single-step, 10 burst, 11 divided run
//   step       one-cycle pulse, starts a step or a burst
//   burst_len  burst pulse count, sampled with step
//   div        divided run: one pulse every div+1 cycles
//   ch_mask    per-channel enable
//   clk_out    gated clocks
//   clk_en     per-channel enable presented to the gates (gate & ch_mask)
//   running    state is RUN or BURST
//   halted     state is HALT
//   cycle_cnt  number of gate pulses issued (wraps)
module clock_ctrl #(
  parameter int N_CH  = 2,
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             hlt,
  input  logic             resume,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [DIV_W-1:0] div,
  input  logic [N_CH-1:0]  ch_mask,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  clk_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [1:0] M_FREE  = 2'b00;
  localparam logic [1:0] M_STEP  = 2'b01;
  localparam logic [1:0] M_BURST = 2'b10;
  localparam logic [1:0] M_DIV   = 2'b11;

  state_t           state;
  logic             gate;
  logic [CNT_W-1:0] remaining;
  logic [DIV_W-1:0] div_cnt;

  // One divided-run step: returns {gate, next div_cnt}. A div lowered below
  // the current count wraps the counter to 0 without issuing a pulse.
  function automatic logic [DIV_W:0] div_step(input logic [DIV_W-1:0] cnt,
                                              input logic [DIV_W-1:0] d);
    if (cnt == d)     return {1'b1, {DIV_W{1'b0}}};
    else if (cnt > d) return {1'b0, {DIV_W{1'b0}}};
    else              return {1'b0, cnt + DIV_W'(1)};
  endfunction

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gate      <= 1'b0;
      running   <= 1'b0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
      remaining <= '0;
      div_cnt   <= '0;
    end else begin
      // Counts pulses actually committed, regardless of which channels pass them.
      if (gate) cycle_cnt <= cycle_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (hlt) begin
            state  <= HALT;
            gate   <= 1'b0;
            halted <= 1'b1;
          end else if (mode == M_FREE) begin
            state   <= RUN;
            gate    <= 1'b1;
            running <= 1'b1;
          end else if (mode == M_DIV) begin
            state             <= RUN;
            {gate, div_cnt}   <= div_step(div_cnt, div);
            running           <= 1'b1;
          end else if (mode == M_STEP && step) begin
            state     <= BURST;
            remaining <= CNT_W'(1);
            gate      <= 1'b1;
            running   <= 1'b1;
          end else if (mode == M_BURST && step && burst_len != '0) begin
            state     <= BURST;
            remaining <= burst_len;
            gate      <= 1'b1;
            running   <= 1'b1;
          end else begin
            gate <= 1'b0;
          end
        end

        RUN: begin
          if (hlt) begin
            state   <= HALT;
            gate    <= 1'b0;
            div_cnt <= '0;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (mode == M_FREE) begin
            gate    <= 1'b1;
            div_cnt <= '0;
          end else if (mode == M_DIV) begin
            {gate, div_cnt} <= div_step(div_cnt, div);
          end else begin
            state   <= IDLE;
            gate    <= 1'b0;
            div_cnt <= '0;
            running <= 1'b0;
          end
        end

        BURST: begin
          // gate is 1 throughout BURST, so every edge here issues a pulse.
          if (hlt) begin
            state     <= HALT;
            gate      <= 1'b0;
            remaining <= '0;
            running   <= 1'b0;
            halted    <= 1'b1;
          end else if (remaining == CNT_W'(1)) begin
            state     <= IDLE;
            gate      <= 1'b0;
            remaining <= '0;
            running   <= 1'b0;
          end else begin
            gate      <= 1'b1;
            remaining <= remaining - CNT_W'(1);
          end
        end

        HALT: begin
          gate <= 1'b0;
          if (resume && !hlt) begin
            state  <= IDLE;
            halted <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          gate    <= 1'b0;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en = {N_CH{gate}} & ch_mask;

  // Low-phase latch gate: the enable is captured while clk_in is low and held
  // through the high phase, so a mask or gate change can never cut or create
  // a partial pulse. Reset forces the outputs low at once.
`ifdef SYNTHESIS
  logic [N_CH-1:0] gclk;
  for (genvar i = 0; i < N_CH; i++) begin : g_icg
    sg13g2_slgcp_1 u_icg (
      .GATE (clk_en[i]),
      .SCE  (1'b0),
      .CLK  (clk_in),
      .GCLK (gclk[i])
    );
  end
  assign clk_out = gclk & {N_CH{~rst}};
`else
  logic [N_CH-1:0] en_lat;
  always_latch begin
    if (rst)          en_lat <= '0;
    else if (!clk_in) en_lat <= clk_en;
  end
  assign clk_out = {N_CH{clk_in}} & en_lat;
`endif

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Parametrised clock controller for the SAP-3 core and its peripherals. It produces N_CH gated clocks from one input clock, with these modes:
- free-run
- single-step
- fixed-length burst
- divided run
Halt is sticky: a CPU halt stops every channel until software or debug logic issues an explicit resume. Each channel has a glitch-free low-phase-latch gate: the IHP integrated clock-gate cell under SYNTHESIS, a behavioural latch otherwise.

Parameters:
N_CH, 2, number of gated clock channels
DIV_W, 8, width of divider setting
CNT_W, 16, width of burst length and cycle counter

Ports:
clk_in  input  1  free-running source clock
rst  input  1  reset, asynchronous, active-high
hlt  input  1  CPU halt request, level, sampled on clk_in rising edge
resume  input  1  one-cycle pulse; leaves HALT
mode  input  2  00 free-run, 01 single-step, 10 burst, 11 divided run
step  input  1  one-cycle pulse; starts step/burst
burst_len  input  CNT_W  burst cycle count, sampled with step
div  input  DIV_W  divided mode: one pulse every div+1 cycles
ch_mask  input  N_CH  per-channel enable (1 = channel may clock)
clk_out  output  N_CH  gated clocks
clk_en  output  N_CH  registered per-channel enable (gate & ch_mask)
running  output  1  state is RUN or BURST
halted  output  1  state is HALT
cycle_cnt  output  CNT_W  count of issued gate pulses, wraps at 2^CNT_W

Behaviour:
- Reset values: state=IDLE, gate=0, clk_en=0, clk_out=0, running=0, halted=0, cycle_cnt=0, remaining=0, div_cnt=0. Reset asserted mid-burst aborts the burst immediately and asynchronously.
- Gating and latency:
  - gate is a register; clk_en[i] = gate & ch_mask[i].
  - clk_out[i] = clk_in AND latch(clk_en[i]); the latch is transparent while clk_in is low. No glitches or partial pulses, even when ch_mask changes mid-cycle.
  - gate set at edge t produces a clk_out high phase starting at edge t+1 (latency 1).
- cycle_cnt increments on every edge where gate=1, independent of ch_mask.
- FSM (evaluated each rising edge; hlt has highest priority in every state except HALT):
  - IDLE, gate=0:
    - hlt -> HALT
    - mode 00 or 11 -> RUN
    - mode 01 & step -> BURST, remaining=1
    - mode 10 & step & burst_len!=0 -> BURST, remaining=burst_len
    - mode 10 & step & burst_len==0 -> stay IDLE
  - RUN:
    - mode 00: gate=1 every cycle.
    - mode 11: div_cnt counts 0..div; gate=1 only when div_cnt==div. div=0 means every cycle.
    - div is re-read each cycle. If div is lowered below div_cnt, div_cnt wraps to 0 on the next edge with gate=0.
    - hlt -> HALT. mode changes to 01/10 -> IDLE, gate=0 from that edge.
  - BURST:
    - gate=1 each cycle; remaining decrements per gate pulse.
    - When remaining==1 and a pulse issues -> IDLE. A burst therefore yields exactly burst_len pulses.
    - step, mode and burst_len changes are ignored during BURST.
    - hlt aborts the burst -> HALT.
  - HALT, gate=0, halted=1:
    - resume & !hlt -> IDLE.
    - resume while hlt=1 is ignored; HALT persists.
- hlt is acted on at the edge it is sampled. The gate is already 0 for the following cycle, so at most the pulse committed at the previous edge still issues.
- Simultaneous events:
  - hlt & step in IDLE -> HALT.
  - step while in RUN is ignored.
  - A resume pulse outside HALT is ignored.
- ch_mask=0 on all channels still advances the FSM and cycle_cnt; no clk_out toggles.

Test Plan:
- Reset, then mode=00, ch_mask=11, 10 cycles -> running=1 from cycle 1; both clk_out toggle 9 times from edge 2; cycle_cnt=9. Assert rst mid-run -> clk_out=0 and cycle_cnt=0 immediately.
- mode=10, burst_len=5, step pulse -> exactly 5 clk_out pulses, then state IDLE, running=0, cycle_cnt=5. A second step mid-burst adds no pulses. burst_len=0 with step -> 0 pulses.
- mode=11, div=3, 16 cycles -> gate high on every 4th cycle: 4 pulses. Change div to 0 -> pulse every cycle thereafter.
- Free-run with hlt raised at cycle 6 -> no clk_out pulse after edge 7, halted=1. resume while hlt=1 -> still HALT. Drop hlt, then resume -> IDLE, then RUN (mode 00).
- mode=01, three step pulses spaced 4 cycles apart -> exactly 3 single pulses on each enabled channel; the ch_mask=10 channel-0 clk_out stays 0, and no glitch is observed when toggling ch_mask while clk_in is high.
- IDLE with hlt and step asserted in the same cycle -> HALT, zero pulses, cycle_cnt unchanged.
